// File: rtl/spi_cmd_sched.sv
// Scheduler between the SPI slave front end and NUM_CH peripheral channels:
// one write slot and one read slot, issued over req/ack with timeout and sticky errors.
module spi_cmd_sched #(
  parameter int          NUM_CH   = 4,
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [15:0]          spi_cmd,
  input  logic [7:0]           spi_addr,
  input  logic                 rd_req,
  input  logic [15:0]          spi_cmd_r,
  input  logic [7:0]           spi_addr_r,
  input  logic [39:0]          spi_data_r,
  input  logic                 spi_data_valid_r,
  input  logic                 spi_done,
  input  logic                 err_clr,
  output logic [15:0]          ch_cmd,
  output logic [7:0]           ch_addr,
  output logic [39:0]          ch_wdata,
  output logic [NUM_CH-1:0]    ch_wr_req,
  output logic [NUM_CH-1:0]    ch_rd_req,
  input  logic [NUM_CH-1:0]    ch_ack,
  input  logic [32*NUM_CH-1:0] ch_rd_data,
  output logic [31:0]          spi_data_out_r,
  output logic                 rd_done,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_badch,
  output logic                 err_overrun
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              state, state_nx;
  logic [3:0]          cur_ch, cur_ch_nx;
  logic [7:0]          cnt, cnt_nx;
  logic                wr_pend, wr_pend_nx;
  logic [15:0]         wr_cmd, wr_cmd_nx;
  logic [7:0]          wr_addr, wr_addr_nx;
  logic [39:0]         wr_data, wr_data_nx;
  logic                rd_pend, rd_pend_nx;
  logic [15:0]         rd_cmd, rd_cmd_nx;
  logic [7:0]          rd_addr, rd_addr_nx;
  logic [15:0]         ch_cmd_nx;
  logic [7:0]          ch_addr_nx;
  logic [39:0]         ch_wdata_nx;
  logic [NUM_CH-1:0]   wr_req_nx, rd_req_nx;
  logic [31:0]         dout_nx;
  logic                rd_done_nx;
  logic                set_to, set_bad, set_ovr, wr_clr;
  logic                ack_hit;
  logic [31:0]         rd_sel;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [3:0] ch);
    logic [NUM_CH-1:0] oh;
    for (int i = 0; i < NUM_CH; i++) oh[i] = (ch == 4'(i));
    return oh;
  endfunction

  function automatic logic ch_bad(input logic [15:0] cmd);
    return {1'b0, cmd[15:12]} >= 5'(NUM_CH);
  endfunction

  // Only the channel currently being served may complete the request
  always_comb begin
    ack_hit = 1'b0;
    rd_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_ch == 4'(i)) begin
        ack_hit = ch_ack[i];
        rd_sel  = ch_rd_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cur_ch_nx   = cur_ch;
    cnt_nx      = cnt;
    wr_pend_nx  = wr_pend;
    wr_cmd_nx   = wr_cmd;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    rd_pend_nx  = rd_pend;
    rd_cmd_nx   = rd_cmd;
    rd_addr_nx  = rd_addr;
    ch_cmd_nx   = ch_cmd;
    ch_addr_nx  = ch_addr;
    ch_wdata_nx = ch_wdata;
    wr_req_nx   = '0;
    rd_req_nx   = '0;
    dout_nx     = spi_data_out_r;
    rd_done_nx  = 1'b0;
    set_to      = 1'b0;
    set_bad     = 1'b0;
    set_ovr     = 1'b0;
    wr_clr      = 1'b0;

    case (state)
      IDLE: begin
        if (wr_pend) begin
          if (ch_bad(wr_cmd)) begin
            wr_clr  = 1'b1;
            set_bad = 1'b1;
          end else begin
            state_nx    = WR;
            cur_ch_nx   = wr_cmd[15:12];
            cnt_nx      = '0;
            ch_cmd_nx   = wr_cmd;
            ch_addr_nx  = wr_addr;
            ch_wdata_nx = wr_data;
            wr_req_nx   = ch_onehot(wr_cmd[15:12]);
          end
        end else if (rd_pend && !spi_done) begin
          // The read slot is handed to the bus on issue, so a later rd_req can refill it
          rd_pend_nx = 1'b0;
          if (ch_bad(rd_cmd)) begin
            set_bad    = 1'b1;
            dout_nx    = ERR_DATA;
            rd_done_nx = 1'b1;
          end else begin
            state_nx   = RD;
            cur_ch_nx  = rd_cmd[15:12];
            cnt_nx     = '0;
            ch_cmd_nx  = rd_cmd;
            ch_addr_nx = rd_addr;
            rd_req_nx  = ch_onehot(rd_cmd[15:12]);
          end
        end
      end
      WR: begin
        if (ack_hit) begin
          state_nx = IDLE;
          wr_clr   = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_nx = IDLE;
          wr_clr   = 1'b1;
          set_to   = 1'b1;
        end else begin
          cnt_nx    = cnt + 8'd1;
          wr_req_nx = ch_wr_req;
        end
      end
      RD: begin
        if (spi_done) begin
          state_nx = IDLE;
        end else if (ack_hit) begin
          state_nx   = IDLE;
          dout_nx    = rd_sel;
          rd_done_nx = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_nx   = IDLE;
          set_to     = 1'b1;
          dout_nx    = ERR_DATA;
          rd_done_nx = 1'b1;
        end else begin
          cnt_nx    = cnt + 8'd1;
          rd_req_nx = ch_rd_req;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (spi_done) rd_pend_nx = 1'b0;
    if (rd_req) begin
      rd_pend_nx = 1'b1;
      rd_cmd_nx  = spi_cmd;
      rd_addr_nx = spi_addr;
    end
    if (wr_clr) wr_pend_nx = 1'b0;
    // The write slot stays occupied until its request completes
    if (spi_data_valid_r) begin
      if (wr_pend) begin
        set_ovr = 1'b1;
      end else begin
        wr_pend_nx = 1'b1;
        wr_cmd_nx  = spi_cmd_r;
        wr_addr_nx = spi_addr_r;
        wr_data_nx = spi_data_r;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cur_ch         <= '0;
      cnt            <= '0;
      wr_pend        <= 1'b0;
      wr_cmd         <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
      rd_pend        <= 1'b0;
      rd_cmd         <= '0;
      rd_addr        <= '0;
      ch_cmd         <= '0;
      ch_addr        <= '0;
      ch_wdata       <= '0;
      ch_wr_req      <= '0;
      ch_rd_req      <= '0;
      spi_data_out_r <= '0;
      rd_done        <= 1'b0;
      err_timeout    <= 1'b0;
      err_badch      <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      state          <= state_nx;
      cur_ch         <= cur_ch_nx;
      cnt            <= cnt_nx;
      wr_pend        <= wr_pend_nx;
      wr_cmd         <= wr_cmd_nx;
      wr_addr        <= wr_addr_nx;
      wr_data        <= wr_data_nx;
      rd_pend        <= rd_pend_nx;
      rd_cmd         <= rd_cmd_nx;
      rd_addr        <= rd_addr_nx;
      ch_cmd         <= ch_cmd_nx;
      ch_addr        <= ch_addr_nx;
      ch_wdata       <= ch_wdata_nx;
      ch_wr_req      <= wr_req_nx;
      ch_rd_req      <= rd_req_nx;
      spi_data_out_r <= dout_nx;
      rd_done        <= rd_done_nx;
      err_timeout    <= (err_timeout & ~err_clr) | set_to;
      err_badch      <= (err_badch & ~err_clr) | set_bad;
      err_overrun    <= (err_overrun & ~err_clr) | set_ovr;
    end
  end

  assign busy = (state != IDLE) | wr_pend | rd_pend;

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Randomized bench for spi_cmd_sched: channel responders with per-channel ack delays and a
// transaction-level reference model predicting requests, read returns and error flags.
module tb_spi_cmd_sched;
  localparam int          NUM_CH   = 4;
  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
  localparam int          NEVER    = 255;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [15:0]          spi_cmd = '0;
  logic [7:0]           spi_addr = '0;
  logic                 rd_req = 1'b0;
  logic [15:0]          spi_cmd_r = '0;
  logic [7:0]           spi_addr_r = '0;
  logic [39:0]          spi_data_r = '0;
  logic                 spi_data_valid_r = 1'b0;
  logic                 spi_done = 1'b0;
  logic                 err_clr = 1'b0;
  logic [15:0]          ch_cmd;
  logic [7:0]           ch_addr;
  logic [39:0]          ch_wdata;
  logic [NUM_CH-1:0]    ch_wr_req;
  logic [NUM_CH-1:0]    ch_rd_req;
  logic [NUM_CH-1:0]    ch_ack;
  logic [32*NUM_CH-1:0] ch_rd_data = '0;
  logic [31:0]          spi_data_out_r;
  logic                 rd_done;
  logic                 busy;
  logic                 err_timeout;
  logic                 err_badch;
  logic                 err_overrun;

  always #5 clk = ~clk;

  spi_cmd_sched #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .resetn(resetn), .spi_cmd(spi_cmd), .spi_addr(spi_addr), .rd_req(rd_req),
    .spi_cmd_r(spi_cmd_r), .spi_addr_r(spi_addr_r), .spi_data_r(spi_data_r),
    .spi_data_valid_r(spi_data_valid_r), .spi_done(spi_done), .err_clr(err_clr),
    .ch_cmd(ch_cmd), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wr_req(ch_wr_req),
    .ch_rd_req(ch_rd_req), .ch_ack(ch_ack), .ch_rd_data(ch_rd_data),
    .spi_data_out_r(spi_data_out_r), .rd_done(rd_done), .busy(busy),
    .err_timeout(err_timeout), .err_badch(err_badch), .err_overrun(err_overrun)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    bit          is_rd;
    int          ch;
    logic [15:0] cmd;
    logic [7:0]  addr;
    logic [39:0] wdata;
    int          start;
    int          len;
    bit          clean;
  } req_rec_t;

  req_rec_t    req_q[$];
  int          done_cyc[$];
  logic [31:0] done_dat[$];
  int          cyc = 0;
  int          ack_dly[NUM_CH];
  bit          noise = 1'b0;

  logic [31:0] exp_dout = '0;
  bit          exp_to = 1'b0, exp_bad = 1'b0, exp_ovr = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Records every request window (one record per rise..fall) and every rd_done pulse
  initial begin : monitor
    req_rec_t          cur;
    bit                in_req;
    logic [NUM_CH-1:0] v, first_v;
    in_req  = 1'b0;
    first_v = '0;
    forever begin
      @(negedge clk);
      v = ch_wr_req | ch_rd_req;
      if (!in_req && v != '0) begin
        in_req    = 1'b1;
        first_v   = v;
        cur.is_rd = (ch_rd_req != '0);
        cur.ch    = -1;
        for (int i = 0; i < NUM_CH; i++) if (v[i]) cur.ch = i;
        cur.clean = $onehot(v) && ((ch_wr_req == '0) || (ch_rd_req == '0));
        cur.cmd   = ch_cmd;
        cur.addr  = ch_addr;
        cur.wdata = ch_wdata;
        cur.start = cyc;
        cur.len   = 0;
      end
      if (in_req) begin
        if (v == '0) begin
          in_req = 1'b0;
          req_q.push_back(cur);
        end else begin
          cur.len++;
          if (v != first_v) cur.clean = 1'b0;
        end
      end
      if (rd_done) begin
        done_cyc.push_back(cyc);
        done_dat.push_back(spi_data_out_r);
      end
    end
  end

  // Channel model: ack after ack_dly[ch] cycles of request; optional spurious acks elsewhere
  initial begin : responder
    int                age;
    logic [NUM_CH-1:0] v, a;
    age    = 0;
    ch_ack = '0;
    forever begin
      @(negedge clk);
      v = ch_wr_req | ch_rd_req;
      a = '0;
      if (v != '0) begin
        for (int i = 0; i < NUM_CH; i++) if (v[i] && age == ack_dly[i]) a[i] = 1'b1;
        age++;
      end else begin
        age = 0;
      end
      if (noise)
        for (int i = 0; i < NUM_CH; i++) if (!v[i] && $urandom_range(0, 1) == 1) a[i] = 1'b1;
      ch_ack = a;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_val(input int ch);
    return ch_rd_data[ch*32 +: 32];
  endfunction

  task automatic clear_logs();
    req_q.delete();
    done_cyc.delete();
    done_dat.delete();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || (ch_wr_req | ch_rd_req) != '0) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check_eq({tag, "_bound"}, busy, 1'b0);
    tick();
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_err_to"}, err_timeout, exp_to);
    check_eq({tag, "_err_bad"}, err_badch, exp_bad);
    check_eq({tag, "_err_ovr"}, err_overrun, exp_ovr);
  endtask

  // One isolated transaction predicted from the latency/timeout/bad-channel rules
  task automatic run_op(input bit is_rd, input logic [15:0] cmd, input logic [7:0] addr,
                        input logic [39:0] wdata);
    int n, ch, d, exp_len;
    bit bad, tmo;
    clear_logs();
    ch      = int'(cmd[15:12]);
    bad     = (ch >= NUM_CH);
    d       = bad ? 0 : ack_dly[ch];
    tmo     = !bad && (d >= TIMEOUT);
    exp_len = tmo ? TIMEOUT : d + 1;
    n       = cyc;
    if (is_rd) begin
      spi_cmd = cmd; spi_addr = addr; rd_req = 1'b1;
    end else begin
      spi_cmd_r = cmd; spi_addr_r = addr; spi_data_r = wdata; spi_data_valid_r = 1'b1;
    end
    tick();
    rd_req = 1'b0;
    spi_data_valid_r = 1'b0;
    wait_idle("op");
    if (bad) exp_bad = 1'b1;
    if (tmo) exp_to = 1'b1;
    check_eq("req_count", req_q.size(), bad ? 0 : 1);
    if (!bad && req_q.size() == 1) begin
      check_eq("req_kind", req_q[0].is_rd, is_rd);
      check_eq("req_ch", req_q[0].ch, ch);
      check_eq("req_onehot", req_q[0].clean, 1'b1);
      check_eq("req_cmd", req_q[0].cmd, cmd);
      check_eq("req_addr", req_q[0].addr, addr);
      if (!is_rd) check_eq("req_wdata", req_q[0].wdata, wdata);
      check_eq("req_start", req_q[0].start, n + 2);
      check_eq("req_len", req_q[0].len, exp_len);
    end
    if (is_rd) begin
      exp_dout = (bad || tmo) ? ERR_DATA : rd_val(ch);
      check_eq("done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1) begin
        check_eq("done_cycle", done_cyc[0], bad ? n + 2 : n + 2 + exp_len);
        check_eq("done_data", done_dat[0], exp_dout);
      end
    end else begin
      check_eq("done_count_wr", done_cyc.size(), 0);
    end
    check_eq("dout_hold", spi_data_out_r, exp_dout);
    check_eq("busy_after", busy, 1'b0);
    check_flags("op");
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_to = 1'b0; exp_bad = 1'b0; exp_ovr = 1'b0;
    check_flags("clr");
  endtask

  initial begin
    int n, c, j;
    for (int i = 0; i < NUM_CH; i++) ack_dly[i] = 0;

    // Reset state
    tick(); tick();
    check_eq("rst_wr_req", ch_wr_req, '0);
    check_eq("rst_rd_req", ch_rd_req, '0);
    check_eq("rst_dout", spi_data_out_r, 32'h0);
    check_eq("rst_rd_done", rd_done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_flags("rst");
    resetn = 1'b1;
    tick();

    // Write to ch1, ack one cycle after the first req cycle
    ack_dly[1] = 1;
    run_op(1'b0, 16'h1005, 8'h20, 40'h00_1234_5678);

    // Fastest read: ch2 acks on the first req cycle
    ack_dly[2] = 0;
    ch_rd_data[2*32 +: 32] = 32'hCAFE_0001;
    run_op(1'b1, 16'h2001, 8'h11, '0);

    // Read to a hung channel times out, then clear the flag
    ack_dly[3] = NEVER;
    run_op(1'b1, 16'h3abc, 8'h33, '0);
    pulse_clr();

    // Ack on the very cycle the timeout would fire still succeeds
    ack_dly[0] = TIMEOUT - 1;
    ch_rd_data[0 +: 32] = 32'h1357_9BDF;
    run_op(1'b1, 16'h0042, 8'h44, '0);

    // Write and read pulsed together to ch0: write goes first
    clear_logs();
    ack_dly[0] = 3;
    ch_rd_data[0 +: 32] = 32'h0BAD_F00D;
    spi_cmd_r = 16'h0011; spi_addr_r = 8'h01; spi_data_r = 40'hAB_CDEF_0123; spi_data_valid_r = 1'b1;
    spi_cmd = 16'h0022; spi_addr = 8'h02; rd_req = 1'b1;
    n = cyc;
    tick();
    spi_data_valid_r = 1'b0; rd_req = 1'b0;
    wait_idle("order");
    check_eq("order_count", req_q.size(), 2);
    if (req_q.size() == 2) begin
      check_eq("order_first_kind", req_q[0].is_rd, 1'b0);
      check_eq("order_wr_start", req_q[0].start, n + 2);
      check_eq("order_rd_kind", req_q[1].is_rd, 1'b1);
      check_eq("order_rd_start", req_q[1].start, n + 2 + 4 + 1);
    end
    exp_dout = 32'h0BAD_F00D;
    check_eq("order_dout", spi_data_out_r, exp_dout);

    // Second write while the first is still in flight is dropped
    clear_logs();
    ack_dly[0] = 6;
    ack_dly[2] = 0;
    spi_cmd_r = 16'h0100; spi_addr_r = 8'h05; spi_data_r = 40'h11_2233_4455; spi_data_valid_r = 1'b1;
    tick();
    spi_data_valid_r = 1'b0;
    tick(); tick(); tick();
    spi_cmd_r = 16'h2200; spi_addr_r = 8'h06; spi_data_r = 40'h66_7788_99AA; spi_data_valid_r = 1'b1;
    tick();
    spi_data_valid_r = 1'b0;
    wait_idle("ovr");
    exp_ovr = 1'b1;
    check_eq("ovr_count", req_q.size(), 1);
    if (req_q.size() == 1) begin
      check_eq("ovr_ch", req_q[0].ch, 0);
      check_eq("ovr_wdata", req_q[0].wdata, 40'h11_2233_4455);
    end
    check_flags("ovr");

    // Bad channel read
    run_op(1'b1, 16'h7000, 8'h70, '0);

    // spi_done aborts an in-flight read: no rd_done, data held
    clear_logs();
    ack_dly[1] = NEVER;
    j = $urandom_range(1, 10);
    spi_cmd = 16'h1234; spi_addr = 8'h12; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int k = 0; k < j; k++) tick();
    spi_done = 1'b1;
    c = cyc;
    tick();
    spi_done = 1'b0;
    wait_idle("abort");
    check_eq("abort_count", req_q.size(), 1);
    if (req_q.size() == 1) check_eq("abort_len", req_q[0].len, c + 1 - req_q[0].start);
    check_eq("abort_done", done_cyc.size(), 0);
    check_eq("abort_dout", spi_data_out_r, exp_dout);
    check_flags("abort");

    // spi_done drops a read still waiting behind a write; the write is not aborted
    clear_logs();
    ack_dly[0] = 5;
    spi_cmd_r = 16'h0777; spi_addr_r = 8'h07; spi_data_r = 40'h77; spi_data_valid_r = 1'b1;
    tick();
    spi_data_valid_r = 1'b0;
    spi_cmd = 16'h2777; spi_addr = 8'h08; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    wait_idle("drop");
    check_eq("drop_count", req_q.size(), 1);
    if (req_q.size() == 1) begin
      check_eq("drop_kind", req_q[0].is_rd, 1'b0);
      check_eq("drop_wr_len", req_q[0].len, 6);
    end
    check_eq("drop_done", done_cyc.size(), 0);

    // Randomized isolated transactions
    for (int it = 0; it < 60; it++) begin
      int d, chn;
      logic [15:0] cmd;
      for (int i = 0; i < NUM_CH; i++) begin
        d = $urandom_range(0, 16);
        ack_dly[i] = (d == 16) ? NEVER : d;
        ch_rd_data[i*32 +: 32] = $urandom();
      end
      noise = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) pulse_clr();
      chn = ($urandom_range(0, 3) == 0) ? $urandom_range(NUM_CH, 15) : $urandom_range(0, NUM_CH - 1);
      cmd = {4'(chn), 12'($urandom())};
      run_op($urandom_range(0, 1) == 1, cmd, 8'($urandom()), {8'($urandom()), 32'($urandom())});
    end
    noise = 1'b0;

    // Asynchronous reset while a read request is up
    run_op(1'b1, 16'hF000, 8'hF0, '0);
    ack_dly[3] = NEVER;
    spi_cmd = 16'h3001; spi_addr = 8'h31; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    j = 0;
    while (ch_rd_req == '0 && j < 10) begin
      tick();
      j++;
    end
    check_eq("arst_req_seen", ch_rd_req != '0, 1'b1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_rd_req", ch_rd_req, '0);
    check_eq("arst_wr_req", ch_wr_req, '0);
    check_eq("arst_badch", err_badch, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_dout", spi_data_out_r, 32'h0);
    tick();
    resetn = 1'b1;
    exp_to = 1'b0; exp_bad = 1'b0; exp_ovr = 1'b0; exp_dout = '0;
    tick();

    // Normal service after reset
    ack_dly[2] = 2;
    ch_rd_data[2*32 +: 32] = 32'h5A5A_A5A5;
    run_op(1'b1, 16'h2002, 8'h22, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
